// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: synchronizes SerialIn, frames start/data/parity/stop bits
// and presents each correctly framed word with a one-cycle SetFlag pulse.
module uart_rx_deserializer #(
  parameter int unsigned WORD_SIZE    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 SerialIn,
  output logic [WORD_SIZE-1:0] DataOut,
  output logic                 SetFlag,
  output logic                 FramingError,
  output logic                 ParityError,
  output logic                 Busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_sync_q, rx_sync_d;
  logic [WORD_SIZE-1:0] data_out_q, data_out_d;
  logic                 set_flag_q, set_flag_d;
  logic                 framing_err_q, framing_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 busy_q, busy_d;
  logic                 bit_done;

  assign bit_done = (cnt_q == BIT_LAST);

  always_comb begin
    rx_meta_d = SerialIn;
    rx_sync_d = rx_meta_q;
  end

  // State and datapath registers
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      par_err_q     <= 1'b0;
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      data_out_q    <= '0;
      set_flag_q    <= 1'b0;
      framing_err_q <= 1'b0;
      parity_err_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      par_err_q     <= par_err_d;
      rx_meta_q     <= rx_meta_d;
      rx_sync_q     <= rx_sync_d;
      data_out_q    <= data_out_d;
      set_flag_q    <= set_flag_d;
      framing_err_q <= framing_err_d;
      parity_err_q  <= parity_err_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state, bit timing and shift register
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_sync_q) begin
            state_d   = S_DATA;
            idx_d     = '0;
            par_err_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync_q;
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          cnt_d     = '0;
          par_err_d = (^shift_q) ^ rx_sync_q;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? S_IDLE : S_WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Hold off retriggering on a break until the line is released
      S_WAIT_HIGH: begin
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs, updated on the stop-bit sample
  always_comb begin
    data_out_d    = data_out_q;
    set_flag_d    = 1'b0;
    framing_err_d = framing_err_q;
    parity_err_d  = parity_err_q;
    busy_d        = (state_d != S_IDLE);
    if (state_q == S_STOP && bit_done) begin
      framing_err_d = ~rx_sync_q;
      parity_err_d  = par_err_q;
      if (rx_sync_q) begin
        data_out_d = shift_q;
        set_flag_d = 1'b1;
      end
    end
  end

  assign DataOut      = data_out_q;
  assign SetFlag      = set_flag_q;
  assign FramingError = framing_err_q;
  assign ParityError  = parity_err_q;
  assign Busy         = busy_q;

endmodule
